// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_seq instruction sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

  localparam int SEL_W   = 3;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS_MSB  = 8;
  localparam int RS_LSB  = 6;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_ASR = 4'b1010;
  localparam logic [3:0] OP_ROL = 4'b1011;

  // 0111 and 11xx have no ALU meaning
  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_MOV) || (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file: two read ports latched on rd_en_i, one write port, one combinational debug port.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en_i,
  input  logic [SEL_W-1:0]  ra_sel_i,
  input  logic [SEL_W-1:0]  rb_sel_i,
  output logic [DATA_W-1:0] ra_q_o,
  output logic [DATA_W-1:0] rb_q_o,
  input  logic              we_i,
  input  logic [SEL_W-1:0]  wsel_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [SEL_W-1:0]  dbg_sel_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] ra_q, rb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      ra_q <= '0;
      rb_q <= '0;
    end else begin
      if (we_i) regs_q[wsel_i] <= wdata_i;
      if (rd_en_i) begin
        ra_q <= regs_q[ra_sel_i];
        rb_q <= regs_q[rb_sel_i];
      end
    end
  end

  assign ra_q_o     = ra_q;
  assign rb_q_o     = rb_q;
  assign dbg_data_o = regs_q[dbg_sel_i];

endmodule

// File: rtl/alu_seq.sv
// Four-cycle instruction sequencer around an external combinational ALU.
// Define ALU_SEQ_FLAGS_EN to latch ALU flags on legal write-backs; otherwise flags read 0.
//   state  | meaning
//   IDLE   | ready for an instruction, latch it on valid&ready
//   READ   | latch rd/rs operands from the register file
//   EXEC   | ALU inputs stable, capture result (and flags) at end
//   WB     | write rd and pulse done, or pulse illegal
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_rd,
  output logic [DATA_W-1:0] alu_rs,
  output logic [3:0]        alu_opcode,
  output logic [3:0]        alu_immd,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              done,
  output logic              illegal,
  output logic [3:0]        flags,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state_q, state_d;
  logic [3:0]        opc_q, imm_q;
  logic [SEL_W-1:0]  rd_sel_q, rs_sel_q;
  logic [DATA_W-1:0] result_q;
  logic              accept, legal, wb_we;
  logic              unused_instr;

  assign unused_instr = ^instr[RS_LSB-1:IMM_MSB+1];
  assign accept       = instr_valid && instr_ready;
  assign legal        = op_legal(opc_q);
  assign wb_we        = (state_q == S_WB) && legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opc_q    <= '0;
      imm_q    <= '0;
      rd_sel_q <= '0;
      rs_sel_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opc_q    <= instr[OPC_MSB:OPC_LSB];
        imm_q    <= instr[IMM_MSB:IMM_LSB];
        rd_sel_q <= instr[RD_MSB:RD_LSB];
        rs_sel_q <= instr[RS_MSB:RS_LSB];
      end
      if (state_q == S_EXEC) result_q <= alu_result;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_READ;
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB: begin
        done    = legal;
        illegal = !legal;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [3:0] flags_cap_q, flags_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_cap_q <= '0;
      flags_q     <= '0;
    end else begin
      if (state_q == S_EXEC) flags_cap_q <= alu_flags;
      if (wb_we) flags_q <= flags_cap_q;
    end
  end

  assign flags = flags_q;
`else
  logic unused_flags;
  assign unused_flags = ^alu_flags;
  assign flags        = 4'b0000;
`endif

  alu_seq_regfile #(
    .DATA_W(DATA_W),
    .NREG  (NREG)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_en_i   (state_q == S_READ),
    .ra_sel_i  (rd_sel_q),
    .rb_sel_i  (rs_sel_q),
    .ra_q_o    (alu_rd),
    .rb_q_o    (alu_rs),
    .we_i      (wb_we),
    .wsel_i    (rd_sel_q),
    .wdata_i   (result_q),
    .dbg_sel_i (dbg_sel),
    .dbg_data_o(dbg_data)
  );

  assign alu_opcode = opc_q;
  assign alu_immd   = imm_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; the bench plays the external ALU.
// Opcode 1011 is modelled as "load load_val" so registers can be preloaded.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_bus;
  logic [15:0] alu_rd, alu_rs;
  logic [3:0]  alu_opcode, alu_immd;
  logic [15:0] alu_result;
  logic [3:0]  alu_flags;
  logic        done, illegal;
  logic [3:0]  flags;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;

  int errors = 0;
  int checks = 0;

  logic [15:0] load_val;
  logic [16:0] m_sum;
  logic [15:0] m_res;
  logic        m_c, m_v;

  int          lat;
  logic        got_done, got_ill, post_pulse;
  logic [15:0] exec_rd, exec_rs;
  logic [3:0]  exec_op;

  always #5 clk = ~clk;

  alu_seq #(.DATA_W(16), .NREG(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr_bus),
    .alu_rd     (alu_rd),
    .alu_rs     (alu_rs),
    .alu_opcode (alu_opcode),
    .alu_immd   (alu_immd),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .done       (done),
    .illegal    (illegal),
    .flags      (flags),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  // external ALU model
  always_comb begin
    m_sum = '0;
    m_res = '0;
    m_c   = 1'b0;
    m_v   = 1'b0;
    case (alu_opcode)
      4'b0000: begin
        m_sum = {1'b0, alu_rd} + {1'b0, alu_rs};
        m_res = m_sum[15:0];
        m_c   = m_sum[16];
        m_v   = (alu_rd[15] == alu_rs[15]) && (m_res[15] != alu_rd[15]);
      end
      4'b0001: begin
        m_sum = {1'b0, alu_rd} - {1'b0, alu_rs};
        m_res = m_sum[15:0];
        m_c   = m_sum[16];
        m_v   = (alu_rd[15] != alu_rs[15]) && (m_res[15] != alu_rd[15]);
      end
      4'b1000: m_res = alu_rd << alu_immd;
      4'b1011: m_res = load_val;
      default: m_res = '0;
    endcase
    alu_result = m_res;
    alu_flags  = {m_c, m_v, m_res[15], (m_res == 16'h0000)};
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [3:0] imm);
    return {op, rd, rs, 2'b00, imm};
  endfunction

  function automatic logic [3:0] exp_flags(input logic [3:0] f);
`ifdef ALU_SEQ_FLAGS_EN
    return f;
`else
    return 4'b0000 & f;
`endif
  endfunction

  // Issue one instruction; lat counts the accept cycle as 1. Returns in IDLE after WB.
  task automatic run_instr(input logic [15:0] ins);
    int n;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_bus   = ins;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    lat = 2;
    got_done = 1'b0;
    got_ill  = 1'b0;
    while (lat < 12) begin
      if (lat == 3) begin
        exec_rd = alu_rd;
        exec_rs = alu_rs;
        exec_op = alu_opcode;
      end
      if (done || illegal) begin
        got_done = done;
        got_ill  = illegal;
        break;
      end
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
    post_pulse = done | illegal;
  endtask

  task automatic load_reg(input logic [2:0] r, input logic [15:0] v);
    load_val = v;
    run_instr(enc(4'b1011, r, 3'd0, 4'd0));
  endtask

  task automatic read_reg(input logic [2:0] r, output logic [15:0] v);
    dbg_sel = r;
    #1;
    v = dbg_data;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    checks++;
    if (instr_ready !== 1'b1 || done !== 1'b0 || illegal !== 1'b0 || flags !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl: ready=%b done=%b illegal=%b flags=%b, required 1 0 0 0000",
               instr_ready, done, illegal, flags);
    end
    checks++;
    if (alu_rd !== 16'h0 || alu_rs !== 16'h0 || alu_opcode !== 4'h0 || alu_immd !== 4'h0) begin
      errors++;
      $display("FAIL reset_alu: rd=%h rs=%h op=%h imm=%h, required all 0",
               alu_rd, alu_rs, alu_opcode, alu_immd);
    end
    for (int r = 0; r < 8; r++) begin
      read_reg(r[2:0], v);
      checks++;
      if (v !== 16'h0000) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h, required 0000", r, v);
      end
    end
  endtask

  task automatic test_add();
    logic [15:0] v;
    load_reg(3'd1, 16'h0003);
    load_reg(3'd2, 16'h0004);
    run_instr(enc(4'b0000, 3'd1, 3'd2, 4'd0));
    checks++;
    if (lat !== 4 || got_done !== 1'b1 || got_ill !== 1'b0) begin
      errors++;
      $display("FAIL add_latency: lat=%0d done=%b illegal=%b, required 4 1 0", lat, got_done, got_ill);
    end
    checks++;
    if (post_pulse !== 1'b0) begin
      errors++;
      $display("FAIL add_pulse_width: done/illegal still high after WB, required 0");
    end
    checks++;
    if (exec_rd !== 16'h0003 || exec_rs !== 16'h0004 || exec_op !== 4'b0000) begin
      errors++;
      $display("FAIL add_exec_operands: rd=%h rs=%h op=%h, required 0003 0004 0", exec_rd, exec_rs, exec_op);
    end
    read_reg(3'd1, v);
    checks++;
    if (v !== 16'h0007) begin
      errors++;
      $display("FAIL add_result: r1=%h, required 0007", v);
    end
    checks++;
    if (flags !== exp_flags(4'b0000)) begin
      errors++;
      $display("FAIL add_flags: got %b, required %b", flags, exp_flags(4'b0000));
    end
  endtask

  task automatic test_sub_same();
    logic [15:0] v;
    load_reg(3'd1, 16'h0005);
    run_instr(enc(4'b0001, 3'd1, 3'd1, 4'd0));
    read_reg(3'd1, v);
    checks++;
    if (v !== 16'h0000 || got_done !== 1'b1) begin
      errors++;
      $display("FAIL sub_same: r1=%h done=%b, required 0000 1", v, got_done);
    end
    checks++;
    if (flags !== exp_flags(4'b0001)) begin
      errors++;
      $display("FAIL sub_flags: got %b, required %b", flags, exp_flags(4'b0001));
    end
  endtask

  task automatic test_shl();
    logic [15:0] v;
    load_reg(3'd3, 16'h0F01);
    run_instr(enc(4'b1000, 3'd3, 3'd0, 4'd4));
    read_reg(3'd3, v);
    checks++;
    if (v !== 16'hF010 || lat !== 4) begin
      errors++;
      $display("FAIL shl_result: r3=%h lat=%0d, required F010 4", v, lat);
    end
    checks++;
    if (flags !== exp_flags(4'b0010)) begin
      errors++;
      $display("FAIL shl_flags: got %b, required %b", flags, exp_flags(4'b0010));
    end
  endtask

  task automatic test_illegal();
    logic [15:0] v;
    logic [15:0] exp_regs [8];
    exp_regs = '{16'h0000, 16'h0000, 16'h0004, 16'hF010, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run_instr(enc(4'b0111, 3'd2, 3'd3, 4'd0));
    checks++;
    if (got_ill !== 1'b1 || got_done !== 1'b0 || lat !== 4) begin
      errors++;
      $display("FAIL illegal_pulse: illegal=%b done=%b lat=%0d, required 1 0 4", got_ill, got_done, lat);
    end
    checks++;
    if (post_pulse !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse_width: pulse still high after WB, required 0");
    end
    for (int r = 0; r < 8; r++) begin
      read_reg(r[2:0], v);
      checks++;
      if (v !== exp_regs[r]) begin
        errors++;
        $display("FAIL illegal_reg%0d: got %h, required %h", r, v, exp_regs[r]);
      end
    end
    checks++;
    if (flags !== exp_flags(4'b0010)) begin
      errors++;
      $display("FAIL illegal_flags_hold: got %b, required %b", flags, exp_flags(4'b0010));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] prog [3];
    int acc_cyc [3];
    int idx, cyc, ndone;
    logic acc;
    logic [15:0] v;
    prog  = '{enc(4'b1011, 3'd4, 3'd0, 4'd0), enc(4'b0000, 3'd4, 3'd4, 4'd0),
              enc(4'b0000, 3'd4, 3'd4, 4'd0)};
    acc_cyc = '{0, 0, 0};
    load_val = 16'h0001;
    idx = 0;
    cyc = 0;
    ndone = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_bus   = prog[0];
    while ((idx < 3 || ndone < 3) && cyc < 60) begin
      acc = instr_valid && instr_ready;
      if (acc) acc_cyc[idx] = cyc;
      if (done) ndone++;
      @(negedge clk);
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 3) instr_bus = prog[idx];
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (idx !== 3 || ndone !== 3) begin
      errors++;
      $display("FAIL b2b_count: accepted=%0d done=%0d, required 3 3", idx, ndone);
    end
    checks++;
    if (acc_cyc[1] - acc_cyc[0] !== 4 || acc_cyc[2] - acc_cyc[1] !== 4) begin
      errors++;
      $display("FAIL b2b_spacing: gaps %0d %0d, required 4 4",
               acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
    end
    read_reg(3'd4, v);
    checks++;
    if (v !== 16'h0004) begin
      errors++;
      $display("FAIL b2b_result: r4=%h, required 0004", v);
    end
  endtask

  task automatic test_reset_exec();
    logic [15:0] v;
    int n;
    int spurious;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_bus   = enc(4'b0000, 3'd2, 3'd3, 4'd0);
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (alu_rd !== 16'h0004 || alu_rs !== 16'hF010) begin
      errors++;
      $display("FAIL rstexec_in_exec: rd=%h rs=%h, required 0004 F010", alu_rd, alu_rs);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1 || done !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL rstexec_ready: ready=%b done=%b illegal=%b, required 1 0 0", instr_ready, done, illegal);
    end
    spurious = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || illegal || !instr_ready) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      errors++;
      $display("FAIL rstexec_idle: %0d cycles left idle, required 0", spurious);
    end
    for (int r = 0; r < 8; r++) begin
      read_reg(r[2:0], v);
      checks++;
      if (v !== 16'h0000) begin
        errors++;
        $display("FAIL rstexec_reg%0d: got %h, required 0000", r, v);
      end
    end
    load_reg(3'd2, 16'h1234);
    read_reg(3'd2, v);
    checks++;
    if (v !== 16'h1234 || lat !== 4) begin
      errors++;
      $display("FAIL rstexec_recover: r2=%h lat=%0d, required 1234 4", v, lat);
    end
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr_bus   = 16'h0000;
    dbg_sel     = 3'd0;
    load_val    = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_add();
    test_sub_same();
    test_shl();
    test_illegal();
    test_back_to_back();
    test_reset_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
